// File: rtl/comm_master.sv
// rtl/comm_master.sv - UART command master: sends a 3-byte 8N1 frame, then waits for a 1-byte response.
module comm_master #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        snd_cmd,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  input  logic        clr_resp_rdy,
  input  logic        RX,
  output logic        TX,
  output logic        busy,
  output logic        frm_sent,
  output logic [7:0]  resp,
  output logic        resp_rdy
);

  localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BAUD_MAX = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_MAX = CW'(BAUD_DIV / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    TX_CMD,
    TX_DHI,
    TX_DLO,
    WAIT_RESP
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_idx;
  logic [3:0]    tx_idx_m1;
  logic [7:0]    cmd_q;
  logic [15:0]   data_q;
  logic [7:0]    tx_byte;
  logic          tx_active;
  logic          tx_byte_end;
  logic          accept;

  logic          rx_meta, rx_sync, rx_prev;
  logic          rx_active;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_idx;
  logic [7:0]    rx_shift;
  logic          rx_start;
  logic          rx_sample;
  logic          rx_done;

  assign accept      = (state == IDLE) && snd_cmd;
  assign tx_active   = (state == TX_CMD) || (state == TX_DHI) || (state == TX_DLO);
  assign tx_byte_end = tx_active && (tx_cnt == BAUD_MAX) && (tx_idx == 4'd9);
  assign tx_idx_m1   = tx_idx - 4'd1;

  // Start bit is checked at mid-bit; every later sample is one full bit time apart.
  assign rx_start  = (state == WAIT_RESP) && !rx_active && rx_prev && !rx_sync;
  assign rx_sample = rx_active && (rx_cnt == ((rx_idx == 4'd0) ? HALF_MAX : BAUD_MAX));
  assign rx_done   = rx_sample && (rx_idx == 4'd9) && rx_sync;

  assign busy     = (state != IDLE);
  assign frm_sent = (state == TX_DLO) && tx_byte_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept)      state_nxt = TX_CMD;
      TX_CMD:    if (tx_byte_end) state_nxt = TX_DHI;
      TX_DHI:    if (tx_byte_end) state_nxt = TX_DLO;
      TX_DLO:    if (tx_byte_end) state_nxt = WAIT_RESP;
      WAIT_RESP: if (rx_done)     state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_byte = cmd_q;
    case (state)
      TX_DHI:  tx_byte = data_q[15:8];
      TX_DLO:  tx_byte = data_q[7:0];
      default: tx_byte = cmd_q;
    endcase
    TX = 1'b1;
    if (tx_active) begin
      if (tx_idx == 4'd0)       TX = 1'b0;
      else if (tx_idx <= 4'd8)  TX = tx_byte[tx_idx_m1[2:0]];
      else                      TX = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_cnt <= '0;
      tx_idx <= '0;
      cmd_q  <= '0;
      data_q <= '0;
    end else if (accept) begin
      cmd_q  <= cmd;
      data_q <= data;
      tx_cnt <= '0;
      tx_idx <= '0;
    end else if (tx_active) begin
      if (tx_cnt == BAUD_MAX) begin
        tx_cnt <= '0;
        tx_idx <= (tx_idx == 4'd9) ? 4'd0 : tx_idx + 4'd1;
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_prev   <= 1'b1;
      rx_active <= 1'b0;
      rx_cnt    <= '0;
      rx_idx    <= '0;
      rx_shift  <= '0;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      if (state != WAIT_RESP) begin
        rx_active <= 1'b0;
        rx_cnt    <= '0;
        rx_idx    <= '0;
      end else if (rx_start) begin
        rx_active <= 1'b1;
        rx_cnt    <= '0;
        rx_idx    <= '0;
      end else if (rx_active) begin
        if (rx_sample) begin
          rx_cnt <= '0;
          if (rx_idx == 4'd0) begin
            // A high line at mid-start means a glitch: go back to hunting.
            if (rx_sync) rx_active <= 1'b0;
            else         rx_idx    <= 4'd1;
          end else if (rx_idx == 4'd9) begin
            rx_active <= 1'b0;
            rx_idx    <= 4'd0;
          end else begin
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_idx   <= rx_idx + 4'd1;
          end
        end else begin
          rx_cnt <= rx_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp     <= 8'h00;
      resp_rdy <= 1'b0;
    end else if (rx_done) begin
      resp     <= rx_shift;
      resp_rdy <= 1'b1;
    end else if (clr_resp_rdy || accept) begin
      resp_rdy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_comm_master.sv
// tb/tb_comm_master.sv - directed self-checking bench for comm_master (BAUD_DIV=16).
module tb_comm_master;
  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        rst, snd_cmd, clr_resp_rdy, RX;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        TX, busy, frm_sent, resp_rdy;
  logic [7:0]  resp;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  comm_master #(.BAUD_DIV(BD)) dut (
    .clk(clk), .rst(rst), .snd_cmd(snd_cmd), .cmd(cmd), .data(data),
    .clr_resp_rdy(clr_resp_rdy), .RX(RX), .TX(TX), .busy(busy),
    .frm_sent(frm_sent), .resp(resp), .resp_rdy(resp_rdy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [29:0] exp_frame(input logic [7:0] c, input logic [15:0] d);
    logic [7:0]  by [3];
    logic [29:0] f;
    by[0] = c; by[1] = d[15:8]; by[2] = d[7:0];
    f = '0;
    for (int b = 0; b < 3; b++) begin
      f[b*10] = 1'b0;
      for (int i = 0; i < 8; i++) f[b*10+1+i] = by[b][i];
      f[b*10+9] = 1'b1;
    end
    return f;
  endfunction

  // Drives a request, then samples TX mid-bit for the 480 cycles that follow acceptance.
  task automatic send_frame(input logic [7:0] c, input logic [15:0] d, input int inj_cyc,
                            input int rst_cyc, output logic [29:0] bits, output int frm_cyc,
                            output int frm_cnt, output bit busy_ok, output logic rdy_c1);
    snd_cmd = 1'b1; cmd = c; data = d;
    bits = '1; frm_cyc = 0; frm_cnt = 0; busy_ok = 1'b1; rdy_c1 = 1'b0;
    @(negedge clk);
    snd_cmd = 1'b0;
    for (int cyc = 1; cyc <= 480; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (cyc == 1) rdy_c1 = resp_rdy;
      if (cyc == inj_cyc) begin
        snd_cmd = 1'b1; cmd = 8'h00; data = 16'h0000;
      end else if (cyc == inj_cyc + 1) begin
        snd_cmd = 1'b0;
      end
      if (cyc == rst_cyc) begin
        chk("tx_before_rst", 32'(TX), 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_tx", 32'(TX), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frm_sent", 32'(frm_sent), 32'd0);
        chk("rst_resp", 32'(resp), 32'h00);
        chk("rst_resp_rdy", 32'(resp_rdy), 32'd0);
        return;
      end
      if ((cyc - 1) % BD == BD / 2) bits[(cyc - 1) / BD] = TX;
      if (!busy) busy_ok = 1'b0;
      if (frm_sent) begin
        frm_cnt++;
        frm_cyc = cyc;
      end
    end
  endtask

  // Drives one 8N1 byte plus an idle bit on RX and records the cycle busy falls.
  task automatic rx_byte(input logic [7:0] b, input logic stop, input bit clr_mode,
                         output bit done, output logic rdy_done, output logic [7:0] resp_done,
                         output logic rdy_after);
    logic [10:0] seq;
    logic        prev_busy;
    int          after;
    seq = {1'b1, stop, b, 1'b0};
    done = 1'b0; rdy_done = 1'b0; resp_done = 8'h00; rdy_after = 1'b0; after = 0;
    prev_busy = busy;
    if (clr_mode) clr_resp_rdy = 1'b1;
    for (int k = 0; k < 11; k++) begin
      RX = seq[k];
      for (int c = 0; c < BD; c++) begin
        @(negedge clk);
        if (after == 1) begin
          rdy_after = resp_rdy;
          clr_resp_rdy = 1'b0;
          after = 2;
        end
        if (prev_busy && !busy && !done) begin
          done = 1'b1;
          rdy_done = resp_rdy;
          resp_done = resp;
          if (clr_mode) after = 1;
        end
        prev_busy = busy;
      end
    end
    clr_resp_rdy = 1'b0;
  endtask

  initial begin
    logic [29:0] bits;
    int          frm_cyc, frm_cnt;
    bit          busy_ok, done, tx_hi;
    logic        rdy_c1, rdy_done, rdy_after;
    logic [7:0]  resp_done;
    int          frm_extra;

    rst = 1'b1; snd_cmd = 1'b0; clr_resp_rdy = 1'b0; RX = 1'b1; cmd = 8'h00; data = 16'h0000;
    repeat (3) @(negedge clk);
    chk("reset_tx", 32'(TX), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_frm_sent", 32'(frm_sent), 32'd0);
    chk("reset_resp", 32'(resp), 32'h00);
    chk("reset_resp_rdy", 32'(resp_rdy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Frame A5/1234 with an ignored request injected mid TX_DHI.
    send_frame(8'hA5, 16'h1234, 200, 0, bits, frm_cyc, frm_cnt, busy_ok, rdy_c1);
    chk("frame1_bits", 32'(bits), 32'(exp_frame(8'hA5, 16'h1234)));
    chk("frame1_frm_cyc", 32'(frm_cyc), 32'd480);
    chk("frame1_frm_cnt", 32'(frm_cnt), 32'd1);
    chk("frame1_busy", 32'(busy_ok), 32'd1);
    tx_hi = 1'b1; frm_extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (!TX) tx_hi = 1'b0;
      if (frm_sent) frm_extra++;
      if (!busy) busy_ok = 1'b0;
    end
    chk("no_second_frame_tx", 32'(tx_hi), 32'd1);
    chk("no_second_frame_frm", 32'(frm_extra), 32'd0);
    chk("wait_resp_busy", 32'(busy_ok), 32'd1);

    rx_byte(8'h0A, 1'b1, 1'b0, done, rdy_done, resp_done, rdy_after);
    chk("rx0a_done", 32'(done), 32'd1);
    chk("rx0a_resp_rdy", 32'(rdy_done), 32'd1);
    chk("rx0a_resp", 32'(resp_done), 32'h0A);
    chk("rx0a_busy", 32'(busy), 32'd0);

    rx_byte(8'h77, 1'b1, 1'b0, done, rdy_done, resp_done, rdy_after);
    chk("idle_rx_resp", 32'(resp), 32'h0A);
    chk("idle_rx_resp_rdy", 32'(resp_rdy), 32'd1);
    chk("idle_rx_busy", 32'(busy), 32'd0);

    send_frame(8'h3C, 16'hBEEF, 0, 0, bits, frm_cyc, frm_cnt, busy_ok, rdy_c1);
    chk("frame2_bits", 32'(bits), 32'(exp_frame(8'h3C, 16'hBEEF)));
    chk("frame2_frm_cyc", 32'(frm_cyc), 32'd480);
    chk("accept_clears_rdy", 32'(rdy_c1), 32'd0);

    rx_byte(8'hFF, 1'b0, 1'b0, done, rdy_done, resp_done, rdy_after);
    chk("ferr_done", 32'(done), 32'd0);
    chk("ferr_resp_rdy", 32'(resp_rdy), 32'd0);
    chk("ferr_resp", 32'(resp), 32'h0A);
    chk("ferr_busy", 32'(busy), 32'd1);

    rx_byte(8'h5A, 1'b1, 1'b0, done, rdy_done, resp_done, rdy_after);
    chk("rx5a_done", 32'(done), 32'd1);
    chk("rx5a_resp_rdy", 32'(rdy_done), 32'd1);
    chk("rx5a_resp", 32'(resp_done), 32'h5A);

    send_frame(8'hE7, 16'h8100, 0, 0, bits, frm_cyc, frm_cnt, busy_ok, rdy_c1);
    chk("frame3_bits", 32'(bits), 32'(exp_frame(8'hE7, 16'h8100)));
    rx_byte(8'h81, 1'b1, 1'b1, done, rdy_done, resp_done, rdy_after);
    chk("clr_done", 32'(done), 32'd1);
    chk("clr_set_wins", 32'(rdy_done), 32'd1);
    chk("clr_resp", 32'(resp_done), 32'h81);
    chk("clr_next_cycle", 32'(rdy_after), 32'd0);

    // Reset while bit 5 of the data high byte (0x55 -> 0) is on the line.
    send_frame(8'hC3, 16'h55AA, 0, 261, bits, frm_cyc, frm_cnt, busy_ok, rdy_c1);
    @(negedge clk);
    rst = 1'b0;
    send_frame(8'h96, 16'h0F0F, 0, 0, bits, frm_cyc, frm_cnt, busy_ok, rdy_c1);
    chk("frame4_bits", 32'(bits), 32'(exp_frame(8'h96, 16'h0F0F)));
    chk("frame4_frm_cyc", 32'(frm_cyc), 32'd480);
    chk("frame4_frm_cnt", 32'(frm_cnt), 32'd1);
    chk("frame4_busy", 32'(busy_ok), 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/comm_master.md
COMM_MASTER -- requirements
Module: comm_master

Interface
REQ-001 The block SHALL have parameter BAUD_DIV, default 2604, giving clk cycles per UART bit time (50 MHz / 19200 baud).
REQ-002 The block SHALL have the port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have the port rst, input, 1 bit: asynchronous active-high reset.
REQ-004 The block SHALL have the port snd_cmd, input, 1 bit: one-cycle request to send a frame.
REQ-005 The block SHALL have the port cmd, input, 8 bits: command byte, sampled when snd_cmd is accepted.
REQ-006 The block SHALL have the port data, input, 16 bits: payload, sampled when snd_cmd is accepted.
REQ-007 The block SHALL have the port clr_resp_rdy, input, 1 bit: clears resp_rdy.
REQ-008 The block SHALL have the port RX, input, 1 bit: serial response line from the responder, asynchronous, idle high.
REQ-009 The block SHALL have the port TX, output, 1 bit: serial command line to the responder, idle high.
REQ-010 The block SHALL have the port busy, output, 1 bit: high from acceptance until the response is received.
REQ-011 The block SHALL have the port frm_sent, output, 1 bit: one-cycle pulse when the last stop bit of the frame completes.
REQ-012 The block SHALL have the port resp, output, 8 bits: last valid response byte received.
REQ-013 The block SHALL have the port resp_rdy, output, 1 bit: high when resp holds a new, unread byte.

Function
REQ-014 Frame SHALL be 3 bytes, back-to-back with no idle gap: cmd, then data[15:8], then data[7:0].
REQ-015 Each byte SHALL be 8N1: start bit 0, data bits LSB first, stop bit 1, each bit exactly BAUD_DIV cycles, so 30*BAUD_DIV cycles per frame.
REQ-016 snd_cmd SHALL be accepted only in IDLE, with TX start bit driven the cycle after acceptance; snd_cmd in any other state SHALL be ignored, with no change to captured values.
REQ-017 Acceptance SHALL capture cmd and data into internal registers, clear resp_rdy, and set busy.
REQ-018 State machine SHALL be IDLE -> TX_CMD -> TX_DHI -> TX_DLO -> WAIT_RESP -> IDLE; each TX_* state advances after its stop bit's last cycle.
REQ-019 frm_sent SHALL pulse in the cycle TX_DLO -> WAIT_RESP.
REQ-020 RX SHALL pass a 2-flop synchronizer preset to 1.
REQ-021 The receiver SHALL be armed only in WAIT_RESP; line activity in other states SHALL be ignored.
REQ-022 Start SHALL be a synchronized falling edge; start bit sampled at BAUD_DIV/2, then each data bit and the stop bit sampled every BAUD_DIV cycles.
REQ-023 A start sample reading 1 SHALL be a glitch: return to hunting for a start edge, no output change.
REQ-024 On a stop sample of 1, resp SHALL load the byte, resp_rdy SHALL set, busy SHALL clear, and the state SHALL go to IDLE, all in the same cycle.
REQ-025 On a stop sample of 0 (framing error), the byte SHALL be discarded, resp/resp_rdy unchanged, and the block SHALL stay in WAIT_RESP hunting for a new start edge.
REQ-026 clr_resp_rdy SHALL clear resp_rdy; if it coincides with setting resp_rdy (REQ-024), set SHALL win.
REQ-027 snd_cmd accepted in the same cycle as clr_resp_rdy SHALL also clear resp_rdy.
REQ-028 The bit counter SHALL count to exactly BAUD_DIV-1 then wrap to 0; a 4-bit bit index SHALL count 0..9 per byte.

Reset
REQ-029 On rst assertion, immediately and regardless of clk, the block SHALL set state IDLE, TX=1, busy=0, frm_sent=0, resp=8'h00, resp_rdy=0, synchronizer=1, and all counters and captured registers to 0.
REQ-030 Reset mid-frame SHALL abort transmission with TX high at once; no partial byte SHALL resume after release.
REQ-031 The first snd_cmd SHALL be accepted in the first clk edge after rst deasserts.

Verification (BAUD_DIV=16)
REQ-032 The bench SHALL drive snd_cmd with cmd=8'hA5 and data=16'h1234 and SHALL check that TX carries bytes A5, 12, 34 LSB first; frm_sent pulses exactly 480 cycles after acceptance; and busy stays high.
REQ-033 The bench SHALL drive RX with byte 8'h0A (valid stop) in WAIT_RESP and SHALL check that resp=0A, resp_rdy=1, busy=0, and state IDLE after the stop sample.
REQ-034 The bench SHALL drive RX with byte 8'hFF and a stop bit of 0 and SHALL check that resp_rdy stays 0; a following valid 8'h5A SHALL be accepted.
REQ-035 The bench SHALL pulse snd_cmd during TX_DHI with cmd=8'h00 and SHALL check that the frame in progress is unchanged and no second frame starts.
REQ-036 The bench SHALL assert rst at bit 5 of byte 2 and SHALL check that TX=1 at once, all outputs take reset values, and a new snd_cmd after release sends a clean frame.
REQ-037 The bench SHALL assert clr_resp_rdy in the cycle resp_rdy sets and SHALL check that resp_rdy=1; clr_resp_rdy one cycle later SHALL give resp_rdy=0.
